// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mm_pkg
//  Description : Shared types and constants for the matrix-multiply engine:
//                FSM state encoding, default dimensions and the accumulator
//                output-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mm_state_e;

    localparam int c_def_n    = 8;
    localparam int c_def_in_w = 8;

    // Full-precision product width plus headroom for summing n products
    function automatic int mm_out_w(input int in_w, input int n);
        return 2 * in_w + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_mac.sv
`default_nettype none
// ============================================================================
//  Module      : mm_mac
//  Description : Signed multiply-accumulate slice. The product is kept at full
//                2*IN_W precision, sign-extended to OUT_W and added with plain
//                modulo-2^OUT_W wrap. 'load' takes priority and replaces the
//                accumulator with load_val.
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_mac #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic                    load,
    input  logic signed [OUT_W-1:0] load_val,
    input  logic                    en,
    output logic signed [OUT_W-1:0] acc
);

    logic signed [2*IN_W-1:0] w_prod;
    logic signed [OUT_W-1:0]  w_prod_ext;
    logic signed [OUT_W-1:0]  r_acc;

    assign w_prod     = a * b;
    assign w_prod_ext = {{(OUT_W-2*IN_W){w_prod[2*IN_W-1]}}, w_prod};
    assign acc        = r_acc;

    // Accumulator register: preload wins over accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (load) begin
            r_acc <= load_val;
        end else if (en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mm_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mm_engine
//  Description : N x N signed matrix multiplier, C = A*B or C = C + A*B, with
//                optional B transpose. One MAC slice walks every C element in
//                row-major order: N MAC cycles then one WRITE cycle each.
//                A/B are host-loaded while idle; C is read through a
//                registered port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_engine
    import mm_pkg::*;
#(
    parameter int N     = c_def_n,
    parameter int IN_W  = c_def_in_w,
    parameter int OUT_W = mm_out_w(IN_W, N),
    parameter int AW    = $clog2(N*N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_mem,
    input  logic                    wenA,
    input  logic                    wenB,
    input  logic [AW-1:0]           addrA,
    input  logic [AW-1:0]           addrB,
    input  logic [AW-1:0]           addrC,
    input  logic signed [IN_W-1:0]  wdA,
    input  logic signed [IN_W-1:0]  wdB,
    output logic signed [OUT_W-1:0] rdC,
    input  logic                    start,
    input  logic                    acc_en,
    input  logic                    transpose_b,
    output logic                    busy,
    output logic                    done
);

    localparam int              c_lw     = $clog2(N);
    localparam logic [c_lw-1:0] c_k_last = c_lw'(N-1);
    localparam logic [AW-1:0]   c_e_last = AW'(N*N-1);

    // Storage: no reset so the arrays map onto RAM
    logic signed [IN_W-1:0]  r_mem_a [N*N];
    logic signed [IN_W-1:0]  r_mem_b [N*N];
    logic signed [OUT_W-1:0] r_mem_c [N*N];

    mm_state_e               r_state;
    mm_state_e               w_state_nxt;
    logic [c_lw-1:0]         r_k;
    logic [AW-1:0]           r_idx;      // {i, j} of the element in flight
    logic                    r_acc_en;
    logic                    r_tb;
    logic signed [OUT_W-1:0] r_rdc;

    logic                    w_go;
    logic                    w_load_win;
    logic [c_lw-1:0]         w_i;
    logic [c_lw-1:0]         w_j;
    logic [AW-1:0]           w_addr_a;
    logic [AW-1:0]           w_addr_b;
    logic [AW-1:0]           w_idx_nxt;
    logic [AW-1:0]           w_pre_addr;
    logic                    w_pre_use;
    logic signed [OUT_W-1:0] w_pre_val;
    logic signed [OUT_W-1:0] w_acc;

    assign w_go       = (r_state == IDLE) && start && !load_mem;
    assign w_load_win = (r_state == IDLE) && load_mem;
    assign w_i        = r_idx[AW-1:c_lw];
    assign w_j        = r_idx[c_lw-1:0];
    assign w_addr_a   = {w_i, r_k};
    assign w_addr_b   = r_tb ? {w_j, r_k} : {r_k, w_j};
    assign w_idx_nxt  = r_idx + AW'(1);

    // Accumulator seed: C[0] on launch, C[next] after each write-back.
    // The mode flag comes straight from the port on launch, since the
    // captured copy is not valid until the same edge.
    assign w_pre_addr = (r_state == IDLE) ? '0 : w_idx_nxt;
    assign w_pre_use  = (r_state == IDLE) ? acc_en : r_acc_en;
    assign w_pre_val  = w_pre_use ? r_mem_c[w_pre_addr] : '0;
    assign rdC        = r_rdc;

    mm_mac #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_mac (
        .clk      (clk),
        .rst      (reset),
        .a        (r_mem_a[w_addr_a]),
        .b        (r_mem_b[w_addr_b]),
        .load     (w_go || (r_state == WRITE)),
        .load_val (w_pre_val),
        .en       (r_state == MAC),
        .acc      (w_acc)
    );

    // Host loads into A/B and result write-back into C
    always_ff @(posedge clk) begin
        if (w_load_win && wenA) r_mem_a[addrA] <= wdA;
        if (w_load_win && wenB) r_mem_b[addrB] <= wdB;
        if (r_state == WRITE)   r_mem_c[r_idx] <= w_acc;
    end

    // Registered C read port; same-cycle write returns the old value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rdc <= '0;
        else       r_rdc <= r_mem_c[addrC];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Loop counters and per-operation mode capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k      <= '0;
            r_idx    <= '0;
            r_acc_en <= 1'b0;
            r_tb     <= 1'b0;
        end else if (w_go) begin
            r_k      <= '0;
            r_idx    <= '0;
            r_acc_en <= acc_en;
            r_tb     <= transpose_b;
        end else if (r_state == MAC) begin
            r_k      <= r_k + c_lw'(1);
        end else if (r_state == WRITE) begin
            r_idx    <= w_idx_nxt;
        end
    end

    // Next-state and status decode
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            IDLE:  if (w_go) w_state_nxt = MAC;
            MAC: begin
                busy = 1'b1;
                if (r_k == c_k_last) w_state_nxt = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                w_state_nxt = (r_idx == c_e_last) ? DONE : MAC;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire
